// File: rtl/vga_pkg.sv
// Shared VGA timing constants, raster-total helpers and the coordinate type
// used by the timing generator, pixel generator and sprite mover.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_ce_delay.sv
// Clock-enabled shift register of DEPTH stages; DEPTH = 0 is a plain wire.
module vga_ce_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, reset, ce};
            assign dout      = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_reg [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            stage_reg[gi] <= '0;
                        end else if (ce) begin
                            stage_reg[gi] <= din;
                        end
                    end
                end else begin : g_tail
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            stage_reg[gi] <= '0;
                        end else if (ce) begin
                            stage_reg[gi] <= stage_reg[gi-1];
                        end
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with pipelined sync/active decode and line, frame and
// animation tick pulses for the downstream pixel and sprite logic.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 1,
    parameter int ANIM_DIV   = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [COORD_W-1:0] counter_x,
    output logic [COORD_W-1:0] counter_y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               anim_tick
);

    localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t     X_LAST    = COORD_W'(H_TOTAL - 1);
    localparam coord_t     Y_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic       POL_XOR   = (SYNC_POL == 0);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
            $error("vga_timing_gen: raster totals exceed coordinate range");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY out of range 0..4");
        end
        if (ANIM_DIV < 1 || ANIM_DIV > 255) begin : g_bad_div
            $error("vga_timing_gen: ANIM_DIV out of range 1..255");
        end
    endgenerate

    coord_t     x_reg, x_next;
    coord_t     y_reg, y_next;
    logic       line_wrap, frame_wrap;
    logic       line_start_reg, frame_start_reg, anim_tick_reg;
    logic [7:0] anim_cnt_reg;
    logic       hs_raw, vs_raw, act_raw;
    logic [2:0] dly;

    always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        line_wrap  = pix_ce && (x_reg == X_LAST);
        frame_wrap = line_wrap && (y_reg == Y_LAST);
        if (pix_ce) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Pulses are registered alongside the counter update so they appear in
    // the first cycle the new coordinate is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            anim_tick_reg   <= 1'b0;
            anim_cnt_reg    <= '0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
            anim_tick_reg   <= frame_wrap && (anim_cnt_reg == ANIM_LAST);
            if (frame_wrap) begin
                anim_cnt_reg <= (anim_cnt_reg == ANIM_LAST) ? 8'd0 : anim_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        hs_raw  = (int'(x_reg) >= HS_START) && (int'(x_reg) < HS_END);
        vs_raw  = (int'(y_reg) >= VS_START) && (int'(y_reg) < VS_END);
        act_raw = (int'(x_reg) < H_ACTIVE) && (int'(y_reg) < V_ACTIVE);
    end

    vga_ce_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (pix_ce),
        .din   ({hs_raw, vs_raw, act_raw}),
        .dout  (dly)
    );

    assign counter_x   = x_reg;
    assign counter_y   = y_reg;
    assign hsync       = dly[2] ^ POL_XOR;
    assign vsync       = dly[1] ^ POL_XOR;
    assign active      = dly[0];
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign anim_tick   = anim_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus three small-raster
// instances (different delay/divider settings) against a step-count model.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset;
    logic       pix_ce;
    logic [9:0] cx [4];
    logic [9:0] cy [4];
    logic       hs [4];
    logic       vs [4];
    logic       act [4];
    logic       ls [4];
    logic       fs [4];
    logic       at [4];

    int     pass_cnt  = 0;
    int     total_cnt = 0;
    int     fail_cnt  = 0;
    longint n_model   = 0;
    bit     stepped_model = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .counter_x(cx[0]), .counter_y(cy[0]), .hsync(hs[0]), .vsync(vs[0]),
        .active(act[0]), .line_start(ls[0]), .frame_start(fs[0]), .anim_tick(at[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .PIPE_DELAY(1), .ANIM_DIV(3)
    ) u_s1 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .counter_x(cx[1]), .counter_y(cy[1]), .hsync(hs[1]), .vsync(vs[1]),
        .active(act[1]), .line_start(ls[1]), .frame_start(fs[1]), .anim_tick(at[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .PIPE_DELAY(0), .ANIM_DIV(1)
    ) u_s0 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .counter_x(cx[2]), .counter_y(cy[2]), .hsync(hs[2]), .vsync(vs[2]),
        .active(act[2]), .line_start(ls[2]), .frame_start(fs[2]), .anim_tick(at[2])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .PIPE_DELAY(3), .ANIM_DIV(3)
    ) u_s3 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .counter_x(cx[3]), .counter_y(cy[3]), .hsync(hs[3]), .vsync(vs[3]),
        .active(act[3]), .line_start(ls[3]), .frame_start(fs[3]), .anim_tick(at[3])
    );

    // Expected outputs derived purely from the number of pixel steps since reset.
    function automatic logic [25:0] model(input int idx, input longint n, input bit stepped);
        longint ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pd, ad;
        longint ht, vt, ft, x, y, m, px, py;
        bit hr, vr, ar, ls_e, fs_e, at_e;
        if (idx == 0) begin
            ha = 640; hfp = 16; hsw = 96; hbp = 48;
            va = 480; vfp = 10; vsw = 2;  vbp = 33;
            pd = 1;   ad = 60;
        end else begin
            ha = 8; hfp = 2; hsw = 3; hbp = 3;
            va = 6; vfp = 1; vsw = 2; vbp = 2;
            pd = (idx == 2) ? 0 : (idx == 3) ? 3 : 1;
            ad = (idx == 2) ? 1 : 3;
        end
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        ft = ht * vt;
        x  = n % ht;
        y  = (n / ht) % vt;
        hr = 0; vr = 0; ar = 0;
        if (n >= pd) begin
            m  = n - pd;
            px = m % ht;
            py = (m / ht) % vt;
            hr = (px >= ha + hfp) && (px < ha + hfp + hsw);
            vr = (py >= va + vfp) && (py < va + vfp + vsw);
            ar = (px < ha) && (py < va);
        end
        ls_e = stepped && (x == 0);
        fs_e = stepped && (n % ft == 0);
        at_e = fs_e && ((n / ft) % ad == 0);
        return {10'(x), 10'(y), ~hr, ~vr, ar, ls_e, fs_e, at_e};
    endfunction

    task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit ce, input bit rst);
        pix_ce = ce;
        reset  = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            n_model = 0;
            stepped_model = 0;
        end else if (ce) begin
            n_model++;
            stepped_model = 1;
        end else begin
            stepped_model = 0;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("state%0d_n%0d", i, n_model),
                  {cx[i], cy[i], hs[i], vs[i], act[i], ls[i], fs[i], at[i]},
                  model(i, n_model, stepped_model));
        end
    endtask

    initial begin
        int waited;
        int ticks1, ticks2, ticks3, frames;
        pix_ce = 1'b0;
        reset  = 1'b1;

        repeat (3) tick(1'b0, 1'b1);
        check("reset_outputs", {16'b0, hs[0], vs[0], act[0], ls[0], fs[0], at[0], cx[0] == 10'd0, cy[0] == 10'd0},
              {16'b0, 6'b110000, 2'b11});

        // pix_ce on every other clock: 800 pixel steps in 1600 clocks
        for (int i = 0; i < 1600; i++) tick(i % 2 == 0, 1'b0);
        check("line1_x", {16'b0, cx[0]}, 26'd0);
        check("line1_y", {16'b0, cy[0]}, 26'd1);

        for (int i = 0; i < 600; i++) tick($urandom_range(0, 3) != 0, 1'b0);

        waited = 0;
        while (cx[0] != 10'd300 && waited < 2000) begin
            tick(1'b1, 1'b0);
            waited++;
        end
        check("reach_x300", {25'b0, cx[0] == 10'd300}, 26'd1);
        repeat (100) tick(1'b0, 1'b0);
        check("hold_x300", {16'b0, cx[0]}, 26'd300);

        // stop the small raster inside both sync regions, then reset with pix_ce high
        waited = 0;
        while (!(cx[1] >= 10'd10 && cx[1] <= 10'd12 && cy[1] >= 10'd7 && cy[1] <= 10'd8)
               && waited < 400) begin
            tick(1'b1, 1'b0);
            waited++;
        end
        check("reach_sync", {25'b0, hs[3] == 1'b1 && cx[1] >= 10'd10}, 26'd1);
        tick(1'b1, 1'b1);
        check("midrst_xy", {6'b0, cx[1], cy[1]}, 26'd0);
        check("midrst_out", {20'b0, hs[1], vs[1], act[1], ls[1], fs[1], at[1]}, {20'b0, 6'b110000});

        ticks1 = 0; ticks2 = 0; ticks3 = 0; frames = 0;
        for (int i = 0; i < 4000 && n_model < 7 * 176; i++) begin
            tick($urandom_range(0, 3) != 0, 1'b0);
            ticks1 += int'(at[1]);
            ticks2 += int'(at[2]);
            ticks3 += int'(at[3]);
            frames += int'(fs[1]);
        end
        check("frames7", 26'(frames), 26'd7);
        check("anim_div3", 26'(ticks1), 26'd2);
        check("anim_div1", 26'(ticks2), 26'd7);
        check("anim_div3_pd3", 26'(ticks3), 26'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing stage for the VGA pixel generator and bouncing-sprite logic.
- Produces the pixel raster counters and the sync and display-enable strobes.
- Delays sync and enable through a pipeline so they align with a registered pixel path.
- Emits per-line, per-frame and animation tick pulses, which replace the free-running wait-counter clock divider in the sprite mover.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high
PIPE_DELAY, 1, pixel-steps of delay on hsync/vsync/active, legal range 0..4
ANIM_DIV, 60, frames per anim_tick, legal range 1..255

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock enable; the raster advances only when this is 1
counter_x  out  10  current horizontal position, 0..H_TOTAL-1
counter_y  out  10  current vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per SYNC_POL, delayed PIPE_DELAY steps
vsync  out  1  vertical sync, polarity per SYNC_POL, delayed PIPE_DELAY steps
active  out  1  1 inside the visible area, delayed PIPE_DELAY steps
line_start  out  1  one-clk pulse when counter_x becomes 0
frame_start  out  1  one-clk pulse when (counter_x, counter_y) becomes (0, 0)
anim_tick  out  1  one-clk pulse on every ANIM_DIV-th frame_start

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
  - Both must be at most 1024; checked at elaboration.
- Counters:
  - On clk with pix_ce = 1, counter_x increments.
  - At H_TOTAL-1 it wraps to 0 and counter_y increments.
  - At V_TOTAL-1 with counter_x = H_TOTAL-1, counter_y wraps to 0.
  - The value H_TOTAL itself is never reached.
  - With pix_ce = 0 all state holds and no pulses are emitted.
- Decode, combinational from the current counters:
  - hs_raw = 1 when H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vs_raw = 1 when V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
  - act_raw = 1 when x < H_ACTIVE and y < V_ACTIVE.
- Delay line:
  - PIPE_DELAY stages, shifting only on pix_ce.
  - PIPE_DELAY = 0 drives the outputs directly from the decode.
  - Output polarity: hsync = hs_d XOR ~SYNC_POL, and likewise for vsync.
- Pulses:
  - line_start, frame_start and anim_tick are registered.
  - Each is high for exactly one clk cycle: the first cycle in which the new counter value is visible.
  - frame_start implies line_start in the same cycle.
- Animation divider:
  - An 8-bit count increments on each frame_start.
  - When the count reaches ANIM_DIV-1 and a frame_start occurs, it returns to 0 and anim_tick pulses together with that frame_start.
  - ANIM_DIV = 1 gives anim_tick on every frame.
- Reset, taking priority over pix_ce:
  - counter_x, counter_y and all delay stages clear to 0.
  - hsync/vsync go to the inactive level (1 when SYNC_POL = 0); active = 0.
  - line_start, frame_start and anim_tick are 0; the divider count is 0.
  - The post-reset (0,0) state is not a transition, so no frame_start or line_start is emitted for it.
  - A reset asserted mid-frame takes effect on the next edge, and any in-flight pulse is dropped.
- Latency:
  - counter_x/y are registered state.
  - Sync and active lag the counters by exactly PIPE_DELAY pix_ce steps.

Decomposition:
- Package vga_pkg holds:
  - the default 640x480@60 timing constants;
  - the H_TOTAL and V_TOTAL derivation functions;
  - the 10-bit coordinate typedef, shared with the pixel generator and sprite mover.
- One sub-module, vga_ce_delay: a parametric-width, parametric-depth shift register with clock enable, depth 0 = passthrough. It is instantiated once with width 3 to carry hs/vs/active.

Test Plan:
- Stimulus: reset for 3 cycles, then pix_ce = 1 on every other clk.
  Required: counter_x reaches 799 then 0 with counter_y = 1 after 1600 clk; hsync low for exactly 96 pixel steps, starting 1 step (PIPE_DELAY = 1) after counter_x = 656.
- Stimulus: run a full frame.
  Required: counter_y never exceeds 524; vsync low for exactly 2 lines (1600 pixel steps); frame_start is a single clk pulse after 420000 pixel steps, coincident with line_start.
- Stimulus: PIPE_DELAY = 0 and 3.
  Required: the active rising edge coincides with counter_x = 0 on line 0, or lags it by 3 steps; active is 0 at x = 640 and at y = 480.
- Stimulus: ANIM_DIV = 3, run 7 frames.
  Required: anim_tick on the 3rd and 6th frame_start only; no pulse at the post-reset (0,0).
- Stimulus: pix_ce held 0 for 100 clk mid-line at x = 300.
  Required: counters hold at 300; no pulses; outputs unchanged.
- Stimulus: reset asserted at x = 700 (inside hsync), y = 491 (inside vsync).
  Required: next cycle counters are 0, hsync = vsync = 1, active = 0, divider cleared, no frame_start.
